// File: rtl/store_buffer.sv
// store_buffer: small store FIFO between the CPU data port and data Memory.
// Stores are queued and drained to Memory one per cycle whenever Memory is not
// taken by a load. Loads have priority. A load whose word has a pending store
// is forwarded on an exact address+size match with the youngest such store,
// otherwise it stalls until that store has drained.
//
// Ports:
//   CLK, Reset          clock, asynchronous active-low reset
//   cpu_addr/cpu_wdata  CPU address and store data
//   cpu_type            size: 0 byte, 1 half, 2..7 word
//   cpu_rd_en/cpu_wr_en load / store request (both high is illegal)
//   cpu_rdata           load data (same cycle)
//   cpu_stall           request not accepted this cycle
//   mem_*               Memory port; mem_read_data is combinational
//   sb_count/sb_empty/sb_full  occupancy status
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  input  logic [2:0]               cpu_type,
  input  logic                     cpu_rd_en,
  input  logic                     cpu_wr_en,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_stall,
  output logic [AW-1:0]            mem_address,
  output logic [DW-1:0]            mem_write_data,
  output logic [2:0]               mem_xfer_size,
  output logic                     mem_write_enable,
  output logic                     mem_read_enable,
  input  logic [DW-1:0]            mem_read_data,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty,
  output logic                     sb_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry storage
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [2:0]       ent_type [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          empty;
  logic          full;
  logic          any_hit;
  logic [PW-1:0] young_idx;
  logic [PW-1:0] scan_idx;
  logic          fwd;
  logic          enq;
  logic          drain;

  // Sizes 2..7 all behave as a word
  function automatic logic [1:0] size_of(input logic [2:0] t);
    case (t)
      3'd0:    return 2'd0;
      3'd1:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [DW-1:0] size_mask(input logic [DW-1:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return DW'(d[7:0]);
      2'd1:    return DW'(d[15:0]);
      default: return d;
    endcase
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign sb_count = count;
  assign sb_empty = empty;
  assign sb_full  = full;

  // Word-granular hit search, oldest to youngest so the last hit wins
  always_comb begin
    any_hit   = 1'b0;
    young_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      scan_idx = head + PW'(k);
      if (ent_valid[scan_idx] && (ent_addr[scan_idx][AW-1:2] == cpu_addr[AW-1:2])) begin
        any_hit   = 1'b1;
        young_idx = scan_idx;
      end
    end
  end

  assign fwd = any_hit && (ent_addr[young_idx] == cpu_addr) &&
               (size_of(ent_type[young_idx]) == size_of(cpu_type));

  // Request arbitration and Memory port steering; everything is quiet in reset
  always_comb begin
    cpu_rdata        = '0;
    cpu_stall        = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_xfer_size    = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    enq              = 1'b0;
    drain            = 1'b0;
    if (Reset) begin
      // Only a load that misses the buffer occupies Memory
      drain     = !empty && !(cpu_rd_en && !cpu_wr_en && !any_hit);
      enq       = cpu_wr_en && !cpu_rd_en && !full;
      cpu_stall = (cpu_rd_en && cpu_wr_en) ||
                  (cpu_wr_en && !cpu_rd_en && full) ||
                  (cpu_rd_en && !cpu_wr_en && any_hit && !fwd);
      if (cpu_rd_en && !cpu_wr_en && !any_hit) begin
        mem_read_enable = 1'b1;
        mem_address     = cpu_addr;
        mem_xfer_size   = cpu_type;
        cpu_rdata       = mem_read_data;
      end else if (drain) begin
        mem_write_enable = 1'b1;
        mem_address      = ent_addr[head];
        mem_write_data   = ent_data[head];
        mem_xfer_size    = ent_type[head];
      end
      if (cpu_rd_en && !cpu_wr_en && fwd) begin
        cpu_rdata = size_mask(ent_data[young_idx], size_of(cpu_type));
      end
    end
  end

  // FIFO state
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_type[i] <= '0;
      end
    end else begin
      if (enq) begin
        ent_addr[tail]  <= cpu_addr;
        ent_data[tail]  <= cpu_wdata;
        ent_type[tail]  <= cpu_type;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      // enq and drain never target the same slot: that needs empty or full
      if (drain) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
